// File: rtl/srcdp_pkg.sv
// rtl/srcdp_pkg.sv - shared types and constants for the srcdp_gen2 datapath
package srcdp_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_e;

    localparam int TMO_W = 8;
    localparam logic [TMO_W-1:0] TMO_RST = '0;
    localparam mem_state_e MEM_RST_STATE = IDLE;
endpackage

// File: rtl/srcdp_regfile.sv
// rtl/srcdp_regfile.sv - 2-read/1-write register file, combinational read, optional hard-zero r0
module srcdp_regfile #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 16,
    parameter int R0_ZERO = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(REG_CNT)-1:0] addr_a,
    input  logic [$clog2(REG_CNT)-1:0] addr_b,
    input  logic [$clog2(REG_CNT)-1:0] addr_c,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata_a,
    output logic [DATA_W-1:0]          rdata_b
);
    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];

    always_comb begin
        regs_d = regs_q;
        if (we && !((R0_ZERO != 0) && (addr_c == '0)))
            regs_d[addr_c] = wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_CNT; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Reads see the pre-write contents, so a same-cycle read of addr_c returns the old value
    always_comb begin
        rdata_a = ((R0_ZERO != 0) && (addr_a == '0)) ? '0 : regs_q[addr_a];
        rdata_b = ((R0_ZERO != 0) && (addr_b == '0)) ? '0 : regs_q[addr_b];
    end
endmodule

// File: rtl/srcdp_gen2.sv
// rtl/srcdp_gen2.sv - MiniSRC datapath with PC, register file, ALU staging regs and handshaked memory port
module srcdp_gen2
    import srcdp_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_CNT  = 16,
    parameter int START_PC = 0,
    parameter int PC_INC   = 1,
    parameter int R0_ZERO  = 1,
    parameter int MEM_TMO  = 255
) (
    input  logic                       iClk,
    input  logic                       iRst,
    input  logic                       iPC_en,
    input  logic                       iPC_jmp,
    input  logic                       iPC_loadRA,
    input  logic                       iPC_loadImm,
    input  logic                       iRF_Write,
    input  logic [$clog2(REG_CNT)-1:0] iRF_AddrA,
    input  logic [$clog2(REG_CNT)-1:0] iRF_AddrB,
    input  logic [$clog2(REG_CNT)-1:0] iRF_AddrC,
    input  logic                       iRA_en,
    input  logic                       iRB_en,
    input  logic [DATA_W-1:0]          iImm,
    input  logic                       iMUX_BIS,
    output logic [DATA_W-1:0]          oALU_A,
    output logic [DATA_W-1:0]          oALU_B,
    input  logic [DATA_W-1:0]          iALU_Hi,
    input  logic [DATA_W-1:0]          iALU_Lo,
    input  logic                       iRZ_en,
    input  logic                       iRAS_en,
    input  logic                       iMUX_RZHS,
    input  logic                       iMUX_ASS,
    input  logic                       iMUX_MAP,
    input  logic                       iMUX_WBM,
    input  logic                       iRWB_en,
    input  logic                       iMemStart,
    input  logic                       iMemWr,
    output logic                       oMemReq,
    output logic                       oMemWe,
    output logic [DATA_W-1:0]          oMemAddr,
    output logic [DATA_W-1:0]          oMemData,
    input  logic [DATA_W-1:0]          iMemData,
    input  logic                       iMemAck,
    output logic                       oMemBusy,
    output logic                       oMemDone,
    output logic                       oMemErr,
    output logic                       oALU_zero,
    output logic                       oALU_neg,
    output logic [DATA_W-1:0]          oPC
);
    logic [DATA_W-1:0] pc_q, pc_d, ra_q, ra_d, rb_q, rb_d;
    logic [DATA_W-1:0] rzh_q, rzh_d, rzl_q, rzl_d, rash_q, rash_d, rasl_q, rasl_d;
    logic [DATA_W-1:0] rwb_q, rwb_d, mdr_q, mdr_d, addr_q, addr_d, data_q, data_d;
    logic [DATA_W-1:0] rf_a, rf_b, rzx;
    logic [TMO_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d, err_q, err_d, mem_busy;
    mem_state_e        state_q, state_d;

    srcdp_regfile #(.DATA_W(DATA_W), .REG_CNT(REG_CNT), .R0_ZERO(R0_ZERO)) u_rf (
        .clk(iClk), .rst(iRst), .we(iRF_Write),
        .addr_a(iRF_AddrA), .addr_b(iRF_AddrB), .addr_c(iRF_AddrC),
        .wdata(rwb_q), .rdata_a(rf_a), .rdata_b(rf_b)
    );

    assign mem_busy = (state_q != IDLE);
    assign rzx = iMUX_ASS ? (iMUX_RZHS ? rash_q : rasl_q) : (iMUX_RZHS ? rzh_q : rzl_q);

    always_comb begin
        pc_d = pc_q;
        if (iPC_en && !mem_busy) begin
            if (iPC_loadRA)       pc_d = ra_q;
            else if (iPC_loadImm) pc_d = iImm;
            else if (iPC_jmp)     pc_d = pc_q + iImm;
            else                  pc_d = pc_q + DATA_W'(PC_INC);
        end
        ra_d   = iRA_en  ? rf_a    : ra_q;
        rb_d   = iRB_en  ? rf_b    : rb_q;
        rzh_d  = iRZ_en  ? iALU_Hi : rzh_q;
        rzl_d  = iRZ_en  ? iALU_Lo : rzl_q;
        rash_d = iRAS_en ? iALU_Hi : rash_q;
        rasl_d = iRAS_en ? iALU_Lo : rasl_q;
        rwb_d  = iRWB_en ? (iMUX_WBM ? mdr_q : rzx) : rwb_q;
    end

    // Memory FSM next-state; a DONE cycle always separates transactions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = we_q;
        err_d   = err_q;
        mdr_d   = mdr_q;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                if (iMemStart) begin
                    state_d = REQ;
                    addr_d  = iMUX_MAP ? pc_q : rzx;
                    data_d  = rb_q;
                    we_d    = iMemWr;
                    cnt_d   = TMO_RST;
                end
            end
            REQ: begin
                if (iMemAck) begin
                    state_d = DONE;
                    if (!we_q) mdr_d = iMemData;
                end else if (cnt_q == TMO_W'(MEM_TMO)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            pc_q    <= DATA_W'(START_PC);
            ra_q    <= '0;
            rb_q    <= '0;
            rzh_q   <= '0;
            rzl_q   <= '0;
            rash_q  <= '0;
            rasl_q  <= '0;
            rwb_q   <= '0;
            mdr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= TMO_RST;
            state_q <= MEM_RST_STATE;
        end else begin
            pc_q    <= pc_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rzh_q   <= rzh_d;
            rzl_q   <= rzl_d;
            rash_q  <= rash_d;
            rasl_q  <= rasl_d;
            rwb_q   <= rwb_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    always_comb begin
        oMemReq   = (state_q == REQ);
        oMemWe    = (state_q == REQ) && we_q;
        oMemDone  = (state_q == DONE);
        oMemErr   = (state_q == DONE) && err_q;
        oMemBusy  = mem_busy;
        oMemAddr  = addr_q;
        oMemData  = data_q;
        oALU_A    = ra_q;
        oALU_B    = iMUX_BIS ? iImm : rb_q;
        oALU_zero = (rzx == '0);
        oALU_neg  = rzx[DATA_W-1];
        oPC       = pc_q;
    end
endmodule

// File: tb/tb_srcdp_gen2.sv
// tb/tb_srcdp_gen2.sv - directed self-checking bench for srcdp_gen2
module tb_srcdp_gen2;
    localparam int MEM_TMO = 255;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm;
    logic        iRF_Write;
    logic [3:0]  iRF_AddrA, iRF_AddrB, iRF_AddrC;
    logic        iRA_en, iRB_en;
    logic [31:0] iImm;
    logic        iMUX_BIS;
    logic [31:0] oALU_A, oALU_B;
    logic [31:0] iALU_Hi, iALU_Lo;
    logic        iRZ_en, iRAS_en, iMUX_RZHS, iMUX_ASS, iMUX_MAP, iMUX_WBM, iRWB_en;
    logic        iMemStart, iMemWr;
    logic        oMemReq, oMemWe;
    logic [31:0] oMemAddr, oMemData, iMemData;
    logic        iMemAck;
    logic        oMemBusy, oMemDone, oMemErr, oALU_zero, oALU_neg;
    logic [31:0] oPC;

    int checks = 0;
    int errors = 0;

    srcdp_gen2 #(.MEM_TMO(MEM_TMO)) dut (
        .iClk(iClk), .iRst(iRst),
        .iPC_en(iPC_en), .iPC_jmp(iPC_jmp), .iPC_loadRA(iPC_loadRA), .iPC_loadImm(iPC_loadImm),
        .iRF_Write(iRF_Write), .iRF_AddrA(iRF_AddrA), .iRF_AddrB(iRF_AddrB), .iRF_AddrC(iRF_AddrC),
        .iRA_en(iRA_en), .iRB_en(iRB_en), .iImm(iImm), .iMUX_BIS(iMUX_BIS),
        .oALU_A(oALU_A), .oALU_B(oALU_B), .iALU_Hi(iALU_Hi), .iALU_Lo(iALU_Lo),
        .iRZ_en(iRZ_en), .iRAS_en(iRAS_en), .iMUX_RZHS(iMUX_RZHS), .iMUX_ASS(iMUX_ASS),
        .iMUX_MAP(iMUX_MAP), .iMUX_WBM(iMUX_WBM), .iRWB_en(iRWB_en),
        .iMemStart(iMemStart), .iMemWr(iMemWr), .oMemReq(oMemReq), .oMemWe(oMemWe),
        .oMemAddr(oMemAddr), .oMemData(oMemData), .iMemData(iMemData), .iMemAck(iMemAck),
        .oMemBusy(oMemBusy), .oMemDone(oMemDone), .oMemErr(oMemErr),
        .oALU_zero(oALU_zero), .oALU_neg(oALU_neg), .oPC(oPC)
    );

    always #5 iClk = ~iClk;

    task automatic tick;
        @(posedge iClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        iRst = 1'b1;
        {iPC_en, iPC_jmp, iPC_loadRA, iPC_loadImm, iRF_Write, iRA_en, iRB_en} = '0;
        {iRF_AddrA, iRF_AddrB, iRF_AddrC} = '0;
        {iMUX_BIS, iRZ_en, iRAS_en, iMUX_RZHS, iMUX_ASS, iMUX_MAP, iMUX_WBM, iRWB_en} = '0;
        {iMemStart, iMemWr, iMemAck} = '0;
        iImm = '0; iALU_Hi = '0; iALU_Lo = '0; iMemData = '0;
        tick; tick;
        iRst = 1'b0;
        chk("rst_pc", oPC, 32'h0);
        chk("rst_req", oMemReq, 1'b0);
        chk("rst_busy", oMemBusy, 1'b0);
        chk("rst_done", oMemDone, 1'b0);
        chk("rst_addr", oMemAddr, 32'h0);
        chk("rst_alu_a", oALU_A, 32'h0);
        chk("rst_alu_b", oALU_B, 32'h0);
        chk("rst_zero", oALU_zero, 1'b1);

        // r3 = 0x12345678 via RZL -> RWB -> RF
        iALU_Lo = 32'h12345678; iRZ_en = 1; tick;
        iRZ_en = 0; iRWB_en = 1; tick;
        iRWB_en = 0;
        iRF_Write = 1; iRF_AddrC = 3; iRF_AddrA = 3; iRA_en = 1; tick;
        chk("rf_read_before_write", oALU_A, 32'h0);
        iRF_Write = 0; tick;
        chk("rf_read_after_write", oALU_A, 32'h12345678);
        iRF_Write = 1; iRF_AddrC = 0; iRF_AddrA = 0; tick;
        iRF_Write = 0; tick;
        chk("rf_r0_zero", oALU_A, 32'h0);
        iRA_en = 0;

        // r5 = 5, RA = r5
        iALU_Lo = 32'd5; iRZ_en = 1; tick;
        iRZ_en = 0; iRWB_en = 1; tick;
        iRWB_en = 0; iRF_Write = 1; iRF_AddrC = 5; tick;
        iRF_Write = 0; iRF_AddrA = 5; iRA_en = 1; tick;
        iRA_en = 0;
        iImm = 32'hFFFFFFFD; iMUX_BIS = 1; #1;
        chk("alu_a_ra", oALU_A, 32'd5);
        chk("alu_b_imm", oALU_B, 32'hFFFFFFFD);
        iMUX_BIS = 0;
        iALU_Hi = 32'd7; iALU_Lo = 32'd9; iRZ_en = 1; tick;
        iRZ_en = 0;
        chk("rzx_lo_zero", oALU_zero, 1'b0);
        chk("rzx_lo_neg", oALU_neg, 1'b0);

        // storage regs hold Hi=0x80000000 / Lo=0 independent of RZ
        iALU_Hi = 32'h80000000; iALU_Lo = 32'h0; iRAS_en = 1; tick;
        iRAS_en = 0; iMUX_ASS = 1; iMUX_RZHS = 1; #1;
        chk("ras_hi_neg", oALU_neg, 1'b1);
        iMUX_RZHS = 0; #1;
        chk("ras_lo_zero", oALU_zero, 1'b1);
        iMUX_ASS = 0; #1;
        chk("rz_lo_again", oALU_zero, 1'b0);

        // ack while idle is ignored
        iMemAck = 1; tick;
        iMemAck = 0;
        chk("idle_ack_busy", oMemBusy, 1'b0);

        // read at address RZX=9 with 3 wait states
        iMUX_MAP = 0; iMemStart = 1; iMemWr = 0; tick;
        iMemStart = 0;
        chk("rd_req", oMemReq, 1'b1);
        chk("rd_busy", oMemBusy, 1'b1);
        chk("rd_addr", oMemAddr, 32'd9);
        chk("rd_we", oMemWe, 1'b0);
        tick; tick;
        chk("rd_wait_req", oMemReq, 1'b1);
        chk("rd_wait_done", oMemDone, 1'b0);
        tick;
        iMemAck = 1; iMemData = 32'hCAFEF00D; tick;
        iMemAck = 0; iMemData = '0;
        chk("rd_done", oMemDone, 1'b1);
        chk("rd_err", oMemErr, 1'b0);
        chk("rd_done_req", oMemReq, 1'b0);
        chk("rd_done_busy", oMemBusy, 1'b1);
        tick;
        chk("rd_done_pulse", oMemDone, 1'b0);
        chk("rd_idle", oMemBusy, 1'b0);
        iMUX_WBM = 1; iRWB_en = 1; tick;
        iRWB_en = 0; iMUX_WBM = 0; iRF_Write = 1; iRF_AddrC = 7; tick;
        iRF_Write = 0; iRF_AddrA = 7; iRA_en = 1; tick;
        iRA_en = 0;
        chk("rd_rwb_mdr", oALU_A, 32'hCAFEF00D);

        // timeout with PC updates requested throughout
        iMemStart = 1; tick;
        iMemStart = 0; iPC_en = 1;
        for (int i = 0; i < MEM_TMO; i++) tick;
        chk("tmo_still_busy", oMemBusy, 1'b1);
        chk("tmo_not_done", oMemDone, 1'b0);
        tick;
        chk("tmo_done", oMemDone, 1'b1);
        chk("tmo_err", oMemErr, 1'b1);
        chk("tmo_pc_blocked", oPC, 32'h0);
        tick;
        iPC_en = 0;
        chk("tmo_idle", oMemBusy, 1'b0);
        chk("tmo_err_clear", oMemErr, 1'b0);
        chk("tmo_pc_still", oPC, 32'h0);

        // PC priority and wrap
        iPC_en = 1; iPC_loadRA = 1; iPC_jmp = 1; iImm = 32'h100; tick;
        chk("pc_loadra_over_jmp", oPC, 32'hCAFEF00D);
        iPC_loadRA = 0; iPC_jmp = 0; iPC_loadImm = 1; iImm = 32'hFFFFFFFF; tick;
        chk("pc_loadimm", oPC, 32'hFFFFFFFF);
        iPC_loadImm = 0; tick;
        chk("pc_wrap", oPC, 32'h0);
        iPC_jmp = 1; iImm = 32'h10; tick;
        chk("pc_jmp", oPC, 32'h10);
        iPC_jmp = 0; iPC_en = 0; tick;
        chk("pc_hold", oPC, 32'h10);

        // write at PC, then reset mid-request
        iRF_AddrB = 7; iRB_en = 1; tick;
        iRB_en = 0; iMUX_MAP = 1; iMemStart = 1; iMemWr = 1; tick;
        iMemStart = 0; iMemWr = 0;
        chk("wr_addr", oMemAddr, 32'h10);
        chk("wr_data", oMemData, 32'hCAFEF00D);
        chk("wr_we", oMemWe, 1'b1);
        iRst = 1; tick;
        chk("rst_mid_req", oMemReq, 1'b0);
        chk("rst_mid_busy", oMemBusy, 1'b0);
        chk("rst_mid_done", oMemDone, 1'b0);
        chk("rst_mid_we", oMemWe, 1'b0);
        iRst = 0; tick;
        chk("rst_mid_no_done", oMemDone, 1'b0);
        chk("rst_mid_pc", oPC, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
